// File: rtl/memc_deskew_drain.sv
// rtl/memc_deskew_drain.sv - realigns a skewed systolic result stream into rows and drains them via valid/ready
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, Cin         lane 0 qualifier and skewed lanes (lane i at bits [i*BITS_C +: BITS_C])
//   in_ready              room for another row, counting rows still in the deskew chain
//   out_valid, out_ready  handshake for the aligned row at the head of the buffer
//   Cout                  aligned row (zero while out_valid is low)
//   row_idx               position of the row on Cout within its DIM-row matrix
//   done                  one-cycle pulse after the last row of a matrix is popped
//   overflow              sticky: an aligned row was dropped because the buffer was full
module memc_deskew_drain #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DIM*BITS_C-1:0]  Cin,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIM*BITS_C-1:0]  Cout,
    output logic [$clog2(DIM)-1:0] row_idx,
    output logic                   done,
    output logic                   overflow
);
    localparam int PW = $clog2(DIM);
    localparam int CW = $clog2(DIM + 1);
    localparam int SW = $clog2(2 * DIM);
    localparam int RW = DIM * BITS_C;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    logic [RW-1:0]  aligned;
    logic [DIM-2:0] vchain;
    logic           aligned_valid;

    logic [RW-1:0]  mem [DIM];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [PW-1:0]  drain;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic [SW-1:0]  pending;
    state_t         state;
    state_t         state_next;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DIM - 1)) ? '0 : p + PW'(1);
    endfunction

    // Lane i is delayed DIM-1-i cycles so that every lane lines up with the
    // last lane, which passes straight through.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        localparam int L = DIM - 1 - i;
        if (L == 0) begin : g_pass
            assign aligned[i*BITS_C +: BITS_C] = Cin[i*BITS_C +: BITS_C];
        end else begin : g_chain
            logic [BITS_C-1:0] chain [L];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < L; k++) chain[k] <= '0;
                end else begin
                    chain[0] <= Cin[i*BITS_C +: BITS_C];
                    for (int k = 1; k < L; k++) chain[k] <= chain[k-1];
                end
            end
            assign aligned[i*BITS_C +: BITS_C] = chain[L-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vchain <= '0;
        end else begin
            vchain[0] <= in_valid;
            for (int k = 1; k < DIM - 1; k++) vchain[k] <= vchain[k-1];
        end
    end

    assign aligned_valid = vchain[DIM-2];

    assign out_valid = (count != '0);
    assign full      = (count == CW'(DIM));
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the head slot, so a full buffer still accepts.
    assign push_ok   = aligned_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= aligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drain    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= inc(wr_ptr);
            if (pop) begin
                rd_ptr <= inc(rd_ptr);
                drain  <= inc(drain);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            done     <= pop & (drain == PW'(DIM - 1));
            overflow <= overflow | (aligned_valid & full & ~pop);
        end
    end

    assign Cout    = out_valid ? mem[rd_ptr] : '0;
    assign row_idx = drain;

    // Rows already in the deskew chain will land in the buffer regardless of
    // in_ready, so they are reserved here.
    always_comb begin
        pending = SW'(count);
        for (int k = 0; k < DIM - 1; k++) pending = pending + SW'(vchain[k]);
    end

    assign in_ready = (pending < SW'(DIM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vchain != '0) state_next = FILL;
            FILL:    if (count != '0) state_next = DRAIN;
            DRAIN:   if (count == '0 && vchain == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_memc_deskew_drain.sv
// tb/tb_memc_deskew_drain.sv - table-driven, directed and randomized checks of memc_deskew_drain
module tb_memc_deskew_drain;
    localparam int DIM = 4;
    localparam int B   = 16;
    localparam int W   = DIM * B;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] Cin;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Cout;
    logic [1:0]   row_idx;
    logic         done;
    logic         overflow;

    memc_deskew_drain #(.BITS_C(B), .DIM(DIM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Cin(Cin), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .Cout(Cout), .row_idx(row_idx),
        .done(done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of whole rows plus a history of launches by age.
    logic [W-1:0] mq[$];
    logic [W-1:0] popped[$];
    bit           hv [DIM];
    logic [W-1:0] hd [DIM];
    bit           m_ovf;
    int           m_drain;
    bit           m_done;

    typedef struct {
        bit           launch;
        logic [W-1:0] row;
        bit           rdy;
        bit           e_ov;
        logic [W-1:0] e_cout;
        logic [1:0]   e_idx;
        bit           e_done;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [W-1:0] mkrow(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        for (int k = 0; k < DIM; k++) begin
            hv[k] = 1'b0;
            hd[k] = '0;
        end
        m_ovf   = 1'b0;
        m_drain = 0;
        m_done  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_cout", Cout, '0);
        chk("rst_row_idx", W'(row_idx), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_overflow", W'(overflow), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        popped.delete();
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic cycle(input bit launch, input logic [W-1:0] row, input bit rdy);
        int infl;
        bit pop;
        infl = 0;
        for (int k = 0; k < DIM - 1; k++) infl += int'(hv[k]);
        chk("out_valid", W'(out_valid), W'(mq.size() > 0));
        chk("cout", Cout, (mq.size() > 0) ? mq[0] : '0);
        chk("row_idx", W'(row_idx), W'(m_drain));
        chk("done", W'(done), W'(m_done));
        chk("overflow", W'(overflow), W'(m_ovf));
        chk("in_ready", W'(in_ready), W'((mq.size() + infl) < DIM));
        for (int k = DIM - 1; k > 0; k--) begin
            hv[k] = hv[k-1];
            hd[k] = hd[k-1];
        end
        hv[0] = launch;
        hd[0] = row;
        in_valid  = launch;
        out_ready = rdy;
        for (int i = 0; i < DIM; i++)
            Cin[i*B +: B] = hv[i] ? hd[i][i*B +: B] : 16'($urandom);
        if (out_valid && rdy) popped.push_back(Cout);
        pop = (mq.size() > 0) && rdy;
        m_done = pop && (m_drain == DIM - 1);
        if (pop) begin
            void'(mq.pop_front());
            m_drain = (m_drain + 1) % DIM;
        end
        if (hv[DIM-1]) begin
            if (mq.size() < DIM) mq.push_back(hd[DIM-1]);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] r [5];
        logic [W-1:0] rx;
        Cin = '0;
        for (int k = 0; k < 5; k++) r[k] = mkrow(10*k, 10*k + 1, 10*k + 2, 10*k + 3);

        tbl[0] = '{1'b1, r[0], 1'b1, 1'b0, '0,   2'd0, 1'b0};
        tbl[1] = '{1'b1, r[1], 1'b1, 1'b0, '0,   2'd0, 1'b0};
        tbl[2] = '{1'b1, r[2], 1'b1, 1'b0, '0,   2'd0, 1'b0};
        tbl[3] = '{1'b1, r[3], 1'b1, 1'b0, '0,   2'd0, 1'b0};
        tbl[4] = '{1'b0, '0,   1'b1, 1'b1, r[0], 2'd0, 1'b0};
        tbl[5] = '{1'b0, '0,   1'b1, 1'b1, r[1], 2'd1, 1'b0};
        tbl[6] = '{1'b0, '0,   1'b1, 1'b1, r[2], 2'd2, 1'b0};
        tbl[7] = '{1'b0, '0,   1'b1, 1'b1, r[3], 2'd3, 1'b0};
        tbl[8] = '{1'b0, '0,   1'b1, 1'b0, '0,   2'd0, 1'b1};
        tbl[9] = '{1'b0, '0,   1'b1, 1'b0, '0,   2'd0, 1'b0};

        do_reset();

        // Single row {1,2,3,4}: visible in cycle 4 only.
        rx = mkrow(1, 2, 3, 4);
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("t1_valid_c%0d", c), W'(out_valid), W'(c == 4));
            if (c == 4) begin
                chk("t1_cout", Cout, rx);
                chk("t1_idx", W'(row_idx), W'(0));
            end
            cycle(c == 0, rx, 1'b1);
        end

        // Four back-to-back rows, table-driven.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t2_valid_c%0d", c), W'(out_valid), W'(tbl[c].e_ov));
            chk($sformatf("t2_cout_c%0d", c), Cout, tbl[c].e_cout);
            chk($sformatf("t2_idx_c%0d", c), W'(row_idx), W'(tbl[c].e_idx));
            chk($sformatf("t2_done_c%0d", c), W'(done), W'(tbl[c].e_done));
            cycle(tbl[c].launch, tbl[c].row, tbl[c].rdy);
        end

        // Stalled consumer: fill, force a 5th row, expect overflow and r0..r3 out.
        do_reset();
        for (int c = 0; c < 5; c++) cycle(1'b1, r[c], 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("t3_full_in_ready", W'(in_ready), W'(0));
        chk("t3_full_valid", W'(out_valid), W'(1));
        cycle(1'b0, '0, 1'b0);
        chk("t3_overflow", W'(overflow), W'(1));
        for (int c = 0; c < 6; c++) cycle(1'b0, '0, 1'b1);
        chk("t3_npop", W'(popped.size()), W'(4));
        for (int k = 0; k < 4 && k < popped.size(); k++)
            chk($sformatf("t3_row%0d", k), popped[k], r[k]);

        // Full buffer popped in the same cycle the 5th row lands: no overflow.
        do_reset();
        for (int c = 0; c < 5; c++) cycle(1'b1, r[c], 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        for (int c = 0; c < 7; c++) cycle(1'b0, '0, 1'b1);
        chk("t4_overflow", W'(overflow), W'(0));
        chk("t4_npop", W'(popped.size()), W'(5));
        for (int k = 0; k < 5 && k < popped.size(); k++)
            chk($sformatf("t4_row%0d", k), popped[k], r[k]);

        // Signed extremes.
        do_reset();
        rx = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        for (int c = 0; c < 4; c++) cycle(c == 0, rx, 1'b1);
        chk("t5_valid", W'(out_valid), W'(1));
        chk("t5_cout", Cout, rx);
        cycle(1'b0, '0, 1'b1);

        // Reset with two rows buffered and one in flight.
        do_reset();
        for (int c = 0; c < 3; c++) cycle(1'b1, r[c], 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("t6_pre_valid", W'(out_valid), W'(1));
        #2;
        do_reset();
        for (int c = 0; c < 6; c++) cycle(1'b0, '0, 1'b1);
        rx = mkrow(7, 8, 9, 11);
        for (int c = 0; c < 4; c++) cycle(c == 0, rx, 1'b1);
        chk("t6_valid", W'(out_valid), W'(1));
        chk("t6_cout", Cout, rx);
        chk("t6_idx", W'(row_idx), W'(0));
        cycle(1'b0, '0, 1'b1);
        chk("t6_npop", W'(popped.size()), W'(1));

        // Randomized traffic against the model, including forced overflows.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rx = {$urandom, $urandom};
            cycle(($urandom % 3) != 0, rx, ($urandom % 4) < ((c / 150) % 2 == 0 ? 3 : 1));
        end
        for (int c = 0; c < 10; c++) cycle(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/memc_deskew_drain.md
# memc_deskew_drain

Result-side counterpart of the B-operand skew FIFOs. It takes the skewed per-column result stream leaving the systolic array and realigns it into whole rows: lane i of a row arrives i cycles after lane 0. It buffers up to DIM aligned rows and drains them to the host/result memory over a valid/ready handshake. It also pulses `done` after each full DIM-row matrix has been drained.

## Interface
Parameters:
- BITS_C, 16, signed width of one result element
- DIM, 8, number of lanes (array width), rows per matrix, and row-buffer depth

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies lane 0 of a new row on Cin[0]
- Cin  input  signed [BITS_C-1:0] x DIM  skewed result lanes
- in_ready  output  1  array may launch a new row this cycle
- out_valid  output  1  aligned row available on Cout
- out_ready  input  1  consumer accepts row when out_valid & out_ready
- Cout  output  signed [BITS_C-1:0] x DIM  aligned row, head of buffer
- row_idx  output  $clog2(DIM)  index (0..DIM-1) of the row on Cout within its matrix
- done  output  1  one-cycle pulse after the DIM-th row of a matrix is popped
- overflow  output  1  sticky: an aligned row arrived while the buffer was full

## Operation
- Deskew: lane i passes through a DIM-1-i stage register chain, so lane DIM-1 has zero delay. in_valid passes through a DIM-1 stage valid chain, giving aligned_valid. Lane registers shift every cycle, with no enable; the array does not stall.
- Lanes shift data regardless of valid. Only the valid chain qualifies a row.
- Row buffer: DIM-entry circular FIFO of full rows. It has read/write pointers that wrap DIM-1→0 and an occupancy count of 0..DIM.
- Push when aligned_valid. Pop when out_valid & out_ready.
- Push and pop in the same cycle:
  - Both take effect and the count is unchanged.
  - This applies even when full: the pop frees the slot, so no overflow is raised.
- Push while full without a pop: the row is dropped, overflow is set, and it stays set until rst. The count and pointers are unchanged.
- in_ready = (count + number of set bits in the valid chain) < DIM. When in_ready is honoured, the buffer cannot overflow.
- in_valid while in_ready=0 is still accepted into the chain. It may later overflow.
- Cout = buffer[rd_ptr] when out_valid, else all zeros.
- Drain counter: 0..DIM-1, increments on each pop and drives row_idx.
  - A pop at row_idx=DIM-1 wraps the counter to 0.
  - That pop asserts done on the next cycle, for one cycle.
- Controller states:
  - IDLE (count=0 and valid chain empty) → FILL when any valid is in the chain.
  - FILL → DRAIN when count>0.
  - DRAIN → IDLE when count=0 and the chain is empty.
  - State is observable only through the outputs; no other behaviour depends on it.

## Timing
- Reset values: in_ready=1, out_valid=0, Cout=0, row_idx=0, done=0, overflow=0. All chains, pointers, count and the drain counter are 0.
- Latency: in_valid with Cin[0] in cycle t. Cin[i] of the same row must be presented in cycle t+i. The row is written at the end of cycle t+DIM-1, and out_valid=1 with the row on Cout in cycle t+DIM (registered, no fall-through).
- Throughput: one row per cycle in and out. Back-to-back in_valid is legal.
- out_valid/Cout hold stable until popped.
- done is registered: pop in cycle p → done high in cycle p+1 only.
- rst mid-operation: all in-flight and buffered rows are discarded immediately, and outputs return to reset values asynchronously.

## Test plan
- DIM=4, BITS_C=16, out_ready=1. Launch row {1,2,3,4} skewed from t=0: Cin[0]=1@0, Cin[1]=2@1, Cin[2]=3@2, Cin[3]=4@3. Required: out_valid=1 in cycle 4 only, Cout={1,2,3,4}, row_idx=0.
- Four back-to-back rows r0..r3 with row k = {10k+0, 10k+1, 10k+2, 10k+3}, out_ready=1. Required: rows out in cycles 4..7 in order, row_idx=0,1,2,3, done=1 in cycle 8 only.
- out_ready=0 and 4 rows launched. Required:
  - count reaches 4 and in_ready=0.
  - A 5th row forced in sets overflow=1.
  - The drained rows are exactly r0..r3.
- Full buffer with out_ready=1 in the same cycle a 5th aligned row arrives. Required: no overflow, and 5 rows drained in order.
- Signed extremes: row {-32768, 32767, -1, 0}. Required: Cout reproduces the values bit-exact.
- Assert rst while 2 rows are buffered and 1 is in flight. Required: out_valid=0 immediately. After release, no stale row ever appears and the next launched row has row_idx=0.
